fixed_div: RTL and testbench
============================

FIXED_DIV -- requirements
Module: fixed_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, total operand/result bit width.
REQ-002 SHALL have parameter FRAC, default 28, fractional bits (Q4.28 at defaults).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a  input  WIDTH signed  dividend, QI.FRAC.
REQ-006 SHALL have port b  input  WIDTH signed  divisor, QI.FRAC.
REQ-007 SHALL have port valid_in  input  1  operand request.
REQ-008 SHALL have port ready  output  1  high when a new operation can be accepted.
REQ-009 SHALL have port result  output  WIDTH signed  quotient a/b, QI.FRAC.
REQ-010 SHALL have port valid_out  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port div_zero  output  1  result produced from b==0.
REQ-012 SHALL have port overflow  output  1  result saturated because the quotient is out of range.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and FIN; ready SHALL equal (state==IDLE).
REQ-014 SHALL accept operands at a rising edge where ready && valid_in; a and b SHALL be sampled only at that edge.
REQ-015 SHALL ignore valid_in while not in IDLE; no queuing.
REQ-016 On accept: register sign = a[MSB]^b[MSB], |a| and |b| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1)), zero flag (b==0), pre-overflow flag (|a| >= |b|<<(WIDTH-FRAC), computed without truncation); go to CALC with iteration counter 0.
REQ-017 CALC SHALL perform radix-2 restoring division of |a|<<FRAC by |b|, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, producing unsigned magnitude q < 2^WIDTH.
REQ-018 When the counter reaches WIDTH-1, the FSM SHALL go to FIN at that edge.
REQ-019 In FIN, at the next edge, the block SHALL register result, div_zero, overflow and valid_out=1, then return to IDLE.
REQ-020 Latency: accept at edge N -> valid_out high for exactly the cycle following edge N+WIDTH+1 (N+33 at defaults), low again after edge N+WIDTH+2.
REQ-021 Throughput: ready SHALL be high during the valid_out cycle; a back-to-back accept SHALL be possible at the edge that clears valid_out.
REQ-022 Rounding SHALL truncate toward zero: result = sign ? -q : q.
REQ-023 Post-saturation: if !sign and q > 2^(WIDTH-1)-1, or sign and q > 2^(WIDTH-1), then result SHALL saturate by sign and overflow=1.
REQ-024 If the pre-overflow flag is set and b!=0, result SHALL saturate by sign with overflow=1; CALC timing SHALL be unchanged.
REQ-025 If b==0: result = (a>=0) ? max positive : min negative, with div_zero=1 and overflow=0; latency SHALL be unchanged; 0/0 SHALL give max positive.
REQ-026 Saturation values SHALL be max positive = 2^(WIDTH-1)-1 and min negative = -2^(WIDTH-1).
REQ-027 A zero quotient with negative sign SHALL yield result 0.
REQ-028 result, div_zero and overflow SHALL hold their values until the next FIN; valid_out SHALL be high for exactly one cycle per accepted operation.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, counter=0, result=0, valid_out=0, div_zero=0, overflow=0, and clear all internal datapath registers.
REQ-030 Reset mid-operation SHALL abort the operation; no valid_out for it; ready SHALL be high from the first cycle after rst_n rises.

Verification
REQ-031 a=0x10000000 (1.0), b=0x20000000 (2.0) -> result 0x08000000, flags 0, valid_out exactly 33 edges after accept.
REQ-032 a=0xD0000000 (-3.0), b=0x08000000 (0.5) -> 0xA0000000 (-6.0); a=0x80000000, b=0x10000000 -> 0x80000000, overflow=0.
REQ-033 Truncation: 0x10000000/0x30000000 -> 0x05555555; 0xF0000000/0x30000000 -> 0xFAAAAAAB.
REQ-034 a=0x70000000 (7.0), b=0x08000000 -> 0x7FFFFFFF, overflow=1; a=0x10000000, b=0x00000001 -> 0x7FFFFFFF, overflow=1 (pre-check path).
REQ-035 Divide by zero: b=0 with a=0x10000000 -> 0x7FFFFFFF, div_zero=1; b=0 with a=0xF0000000 -> 0x80000000, div_zero=1.
REQ-036 Protocol: valid_in held high throughout -> accepts spaced 34 cycles apart, inputs changed mid-CALC do not affect the result; rst_n pulsed low 10 cycles after accept -> no valid_out, outputs 0, next operation correct.

Source files
------------

// File: rtl/fixed_div.sv
// Signed fixed-point divider, QI.FRAC operands, one quotient bit per cycle.
// Saturates on overflow and on divide-by-zero, truncating toward zero.
module fixed_div #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    valid_in,
  output logic                    ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    valid_out,
  output logic                    div_zero,
  output logic                    overflow
);

  localparam int SH = WIDTH - FRAC;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sign;
  logic            zero;
  logic            pre;
  logic [WIDTH-1:0] babs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dq;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] d_ext;
  logic               pre_c;
  logic [WIDTH:0]     trial;
  logic               take;
  logic [WIDTH-1:0]   diff;
  logic               sat;

  assign ready = (state == IDLE);

  assign a_abs = a[WIDTH-1] ? $unsigned(-a) : $unsigned(a);
  assign b_abs = b[WIDTH-1] ? $unsigned(-b) : $unsigned(b);
  assign d_ext = {{WIDTH{1'b0}}, a_abs} << FRAC;

  // Quotient needs more than WIDTH bits when |a| >= |b| << (WIDTH-FRAC)
  assign pre_c = {{SH{1'b0}}, a_abs} >= {b_abs, {SH{1'b0}}};

  // dq holds the unconsumed dividend bits and collects quotient bits
  assign trial = {rem, dq[WIDTH-1]};
  assign take  = trial >= {1'b0, babs};
  assign diff  = trial[WIDTH-1:0] - babs;

  assign sat = pre | (~sign & dq[WIDTH-1]) | (sign & (dq > MINN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sign      <= 1'b0;
      zero      <= 1'b0;
      pre       <= 1'b0;
      babs      <= '0;
      rem       <= '0;
      dq        <= '0;
      result    <= '0;
      valid_out <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_in) begin
            sign  <= a[WIDTH-1] ^ b[WIDTH-1];
            zero  <= (b == '0);
            pre   <= pre_c;
            babs  <= b_abs;
            rem   <= d_ext[2*WIDTH-1:WIDTH];
            dq    <= d_ext[WIDTH-1:0];
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          rem <= take ? diff : trial[WIDTH-1:0];
          dq  <= {dq[WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIN;
        end
        FIN: begin
          valid_out <= 1'b1;
          state     <= IDLE;
          if (zero) begin
            result   <= sign ? MINN : MAXP;
            div_zero <= 1'b1;
            overflow <= 1'b0;
          end else if (sat) begin
            result   <= sign ? MINN : MAXP;
            div_zero <= 1'b0;
            overflow <= 1'b1;
          end else begin
            result   <= sign ? -dq : dq;
            div_zero <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_div.sv
// Randomised bench for fixed_div against an integer-arithmetic model.
// Checks result, flags, latency, ready and output hold every cycle.
module tb_fixed_div;

  localparam int W = 32;
  localparam int F = 28;
  localparam int LAT = W + 1;

  logic                clk;
  logic                rst_n;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic                valid_in;
  logic                ready;
  logic signed [W-1:0] result;
  logic                valid_out;
  logic                div_zero;
  logic                overflow;

  fixed_div #(.WIDTH(W), .FRAC(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .ready     (ready),
    .result    (result),
    .valid_out (valid_out),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } vec_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int next_ok = 0;
  int acc_count = 0;
  logic [W-1:0] last_r = '0;
  logic last_dz = 1'b0;
  logic last_ov = 1'b0;

  // Quotient from plain signed arithmetic, then clamp to the Q range
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic dz,
                                output logic ov);
    longint num;
    longint den;
    longint q;
    num = longint'($signed(x)) * (longint'(1) << F);
    den = longint'($signed(y));
    dz = 1'b0;
    ov = 1'b0;
    if (den == 0) begin
      dz = 1'b1;
      r = ($signed(x) >= 0) ? 32'h7FFFFFFF : 32'h80000000;
    end else begin
      q = num / den;
      if (q > 64'sd2147483647) begin
        r = 32'h7FFFFFFF;
        ov = 1'b1;
      end else if (q < -64'sd2147483648) begin
        r = 32'h80000000;
        ov = 1'b1;
      end else begin
        r = 32'(q);
      end
    end
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && valid_in && cyc >= next_ok) begin
      model(a, b, e.r, e.dz, e.ov);
      e.acc = cyc;
      exp_q.push_back(e);
      next_ok = cyc + LAT + 1;
      acc_count++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (!rst_n) begin
      checks++;
      if (valid_out || result != 0 || div_zero || overflow) begin
        errors++;
        $display("FAIL reset_outputs: got vo%0b r=%h dz%0b ov%0b, expected all 0",
                 valid_out, result, div_zero, overflow);
      end
      last_r = '0;
      last_dz = 1'b0;
      last_ov = 1'b0;
    end else begin
      exp_rdy = (cyc + 1 >= next_ok);
      checks++;
      if (ready !== exp_rdy) begin
        errors++;
        $display("FAIL ready @%0d: got %b, expected %b", cyc, ready, exp_rdy);
      end
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid @%0d: got valid_out 1, expected 0", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.acc + LAT || result !== e.r ||
              div_zero !== e.dz || overflow !== e.ov) begin
            errors++;
            $display("FAIL result @%0d: got %h dz%0b ov%0b at %0d, expected %h dz%0b ov%0b at %0d",
                     cyc, result, div_zero, overflow, cyc,
                     e.r, e.dz, e.ov, e.acc + LAT);
          end
        end
        last_r = result;
        last_dz = div_zero;
        last_ov = overflow;
      end else begin
        checks++;
        if (result !== last_r || div_zero !== last_dz || overflow !== last_ov) begin
          errors++;
          $display("FAIL hold @%0d: got %h dz%0b ov%0b, expected %h dz%0b ov%0b",
                   cyc, result, div_zero, overflow, last_r, last_dz, last_ov);
        end
        if (exp_q.size() != 0 && cyc > exp_q[0].acc + LAT) begin
          checks++;
          errors++;
          $display("FAIL no_valid: got none by %0d, expected at %0d",
                   cyc, exp_q[0].acc + LAT);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got %0d pending after 100 cycles, expected 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle();
    @(negedge clk);
    a = x;
    b = y;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_idle();
  endtask

  vec_t vecs[13] = '{
    '{32'h10000000, 32'h20000000, 32'h08000000, 1'b0, 1'b0},
    '{32'hD0000000, 32'h08000000, 32'hA0000000, 1'b0, 1'b0},
    '{32'h80000000, 32'h10000000, 32'h80000000, 1'b0, 1'b0},
    '{32'h10000000, 32'h30000000, 32'h05555555, 1'b0, 1'b0},
    '{32'hF0000000, 32'h30000000, 32'hFAAAAAAB, 1'b0, 1'b0},
    '{32'h70000000, 32'h08000000, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{32'h10000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{32'h10000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{32'hF0000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0},
    '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{32'h00000000, 32'hF0000000, 32'h00000000, 1'b0, 1'b0},
    '{32'h80000000, 32'hF0000000, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{32'h80000000, 32'h0FFFFFFF, 32'h80000000, 1'b0, 1'b1}
  };

  initial begin
    logic [W-1:0] mr;
    logic mdz;
    logic mov;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int c0;

    rst_n = 1'b0;
    valid_in = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      model(vecs[i].x, vecs[i].y, mr, mdz, mov);
      checks++;
      if (mr !== vecs[i].r || mdz !== vecs[i].dz || mov !== vecs[i].ov) begin
        errors++;
        $display("FAIL model_vec%0d: got %h dz%0b ov%0b, expected %h dz%0b ov%0b",
                 i, mr, mdz, mov, vecs[i].r, vecs[i].dz, vecs[i].ov);
      end
    end

    foreach (vecs[i]) do_op(vecs[i].x, vecs[i].y);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      else ra = $signed(ra) >>> $urandom_range(0, 8);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1, 2: begin
          rb = $urandom >> $urandom_range(8, 31);
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        default: rb = $urandom;
      endcase
      do_op(ra, rb);
    end

    // valid_in held high: operands churn every cycle
    wait_idle();
    @(negedge clk);
    c0 = acc_count;
    valid_in = 1'b1;
    repeat (4 * (LAT + 1) + 2) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 6);
      @(negedge clk);
    end
    valid_in = 1'b0;
    checks++;
    if (acc_count - c0 != 5) begin
      errors++;
      $display("FAIL held_accepts: got %0d, expected 5", acc_count - c0);
    end
    wait_idle();

    // reset part-way through a division
    @(negedge clk);
    a = 32'h10000000;
    b = 32'h20000000;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    next_ok = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b, expected 1", ready);
    end
    do_op(32'hF0000000, 32'h30000000);
    do_op(32'hD0000000, 32'h08000000);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
